// File: rtl/mmio_bram_arbiter.sv
// Shares the MMIO block RAM between host MMIO and one local requester; zero sweep after reset, host has strict priority.
// Reads return at fixed 2-cycle latency; local side back-pressured via loc_req_ready; MMIO_BRAM_ARB_FWD_EN enables write->read forwarding.
module mmio_bram_arbiter #(
  parameter int          DATA_WIDTH = 64,
  parameter int          ADDR_WIDTH = 9,
  parameter logic [15:0] BRAM_BASE  = 16'h0030
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_mmio_rd_valid,
  input  logic                  i_mmio_wr_valid,
  input  logic [15:0]           i_mmio_addr,
  input  logic [8:0]            i_mmio_tid,
  input  logic [DATA_WIDTH-1:0] i_mmio_wr_data,
  output logic                  o_mmio_rsp_valid,
  output logic [8:0]            o_mmio_rsp_tid,
  output logic [DATA_WIDTH-1:0] o_mmio_rsp_data,
  input  logic                  i_loc_req_valid,
  output logic                  o_loc_req_ready,
  input  logic                  i_loc_req_we,
  input  logic [ADDR_WIDTH-1:0] i_loc_req_addr,
  input  logic [DATA_WIDTH-1:0] i_loc_req_wdata,
  output logic                  o_loc_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_loc_rsp_data,
  output logic                  o_init_done,
  output logic                  o_bram_wr_en,
  output logic [ADDR_WIDTH-1:0] o_bram_wr_addr,
  output logic [DATA_WIDTH-1:0] o_bram_wr_data,
  output logic [ADDR_WIDTH-1:0] o_bram_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_bram_rd_data
);

  localparam logic [16:0] WIN_BYTES = 17'(2 * (1 << ADDR_WIDTH));

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_sweep_ptr;
  logic                  r_s1_vld;
  logic                  r_s1_host;
  logic [8:0]            r_s1_tid;

  logic [15:0]           w_off;
  logic                  w_hit;
  logic [ADDR_WIDTH-1:0] w_word;
  logic                  w_host_rd;
  logic                  w_host_wr;
  logic                  w_loc_acc;
  logic                  w_rd_en;
  logic [DATA_WIDTH-1:0] w_s1_data;

  // Odd-address test is done on the offset so every bit of it is consumed.
  assign w_off  = i_mmio_addr - BRAM_BASE;
  assign w_hit  = (i_mmio_addr >= BRAM_BASE) && ({1'b0, w_off} < WIN_BYTES) &&
                  (w_off[0] == BRAM_BASE[0]);
  assign w_word = w_off[ADDR_WIDTH:1];

  always_comb begin
    w_host_rd       = i_mmio_rd_valid && w_hit && !i_rst;
    w_host_wr       = i_mmio_wr_valid && w_hit && !i_rst && (r_state == ST_RUN);
    o_loc_req_ready = !i_rst && (r_state == ST_RUN) &&
                      (i_loc_req_we ? !(i_mmio_wr_valid && w_hit) : !(i_mmio_rd_valid && w_hit));
    w_loc_acc       = i_loc_req_valid && o_loc_req_ready;

    o_bram_wr_en   = 1'b0;
    o_bram_wr_addr = r_sweep_ptr;
    o_bram_wr_data = '0;
    if (!i_rst) begin
      if (r_state == ST_INIT) begin
        o_bram_wr_en = 1'b1;
      end else if (w_host_wr) begin
        o_bram_wr_en   = 1'b1;
        o_bram_wr_addr = w_word;
        o_bram_wr_data = i_mmio_wr_data;
      end else if (w_loc_acc && i_loc_req_we) begin
        o_bram_wr_en   = 1'b1;
        o_bram_wr_addr = i_loc_req_addr;
        o_bram_wr_data = i_loc_req_wdata;
      end
    end

    w_rd_en        = w_host_rd || (w_loc_acc && !i_loc_req_we);
    o_bram_rd_addr = w_host_rd ? w_word : i_loc_req_addr;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_INIT;
      r_sweep_ptr <= '0;
      o_init_done <= 1'b0;
    end else if (r_state == ST_INIT) begin
      r_sweep_ptr <= r_sweep_ptr + 1'b1;
      if (r_sweep_ptr == '1) begin
        r_state     <= ST_RUN;
        o_init_done <= 1'b1;
      end
    end
  end

`ifdef MMIO_BRAM_ARB_FWD_EN
  logic                  r_s1_fwd;
  logic [DATA_WIDTH-1:0] r_s1_fwd_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_fwd      <= 1'b0;
      r_s1_fwd_data <= '0;
    end else begin
      r_s1_fwd      <= w_rd_en && o_bram_wr_en && (o_bram_wr_addr == o_bram_rd_addr);
      r_s1_fwd_data <= o_bram_wr_data;
    end
  end

  assign w_s1_data = r_s1_fwd ? r_s1_fwd_data : i_bram_rd_data;
`else
  assign w_s1_data = i_bram_rd_data;
`endif

  // Stage 1 rides alongside the RAM access; stage 2 registers the response.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_vld         <= 1'b0;
      r_s1_host        <= 1'b0;
      r_s1_tid         <= '0;
      o_mmio_rsp_valid <= 1'b0;
      o_mmio_rsp_tid   <= '0;
      o_mmio_rsp_data  <= '0;
      o_loc_rsp_valid  <= 1'b0;
      o_loc_rsp_data   <= '0;
    end else begin
      r_s1_vld         <= w_rd_en;
      r_s1_host        <= w_host_rd;
      r_s1_tid         <= i_mmio_tid;
      o_mmio_rsp_valid <= r_s1_vld && r_s1_host;
      o_loc_rsp_valid  <= r_s1_vld && !r_s1_host;
      if (r_s1_vld && r_s1_host) begin
        o_mmio_rsp_tid  <= r_s1_tid;
        o_mmio_rsp_data <= w_s1_data;
      end
      if (r_s1_vld && !r_s1_host) begin
        o_loc_rsp_data <= w_s1_data;
      end
    end
  end

endmodule

// File: tb/tb_mmio_bram_arbiter.sv
// Bench for mmio_bram_arbiter: RAM model plus a memory/queue reference model of the arbitration rules.
`timescale 1ns/1ps
module tb_mmio_bram_arbiter;
  localparam int DEPTH = 512;
`ifdef MMIO_BRAM_ARB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mmio_rd_valid, mmio_wr_valid;
  logic [15:0] mmio_addr;
  logic [8:0]  mmio_tid;
  logic [63:0] mmio_wr_data;
  logic        mmio_rsp_valid;
  logic [8:0]  mmio_rsp_tid;
  logic [63:0] mmio_rsp_data;
  logic        loc_req_valid, loc_req_ready, loc_req_we;
  logic [8:0]  loc_req_addr;
  logic [63:0] loc_req_wdata;
  logic        loc_rsp_valid;
  logic [63:0] loc_rsp_data;
  logic        init_done;
  logic        bram_wr_en;
  logic [8:0]  bram_wr_addr, bram_rd_addr;
  logic [63:0] bram_wr_data, bram_rd_data;

  always #5 clk = ~clk;

  mmio_bram_arbiter dut (
    .i_clk(clk), .i_rst(rst),
    .i_mmio_rd_valid(mmio_rd_valid), .i_mmio_wr_valid(mmio_wr_valid),
    .i_mmio_addr(mmio_addr), .i_mmio_tid(mmio_tid), .i_mmio_wr_data(mmio_wr_data),
    .o_mmio_rsp_valid(mmio_rsp_valid), .o_mmio_rsp_tid(mmio_rsp_tid), .o_mmio_rsp_data(mmio_rsp_data),
    .i_loc_req_valid(loc_req_valid), .o_loc_req_ready(loc_req_ready), .i_loc_req_we(loc_req_we),
    .i_loc_req_addr(loc_req_addr), .i_loc_req_wdata(loc_req_wdata),
    .o_loc_rsp_valid(loc_rsp_valid), .o_loc_rsp_data(loc_rsp_data),
    .o_init_done(init_done),
    .o_bram_wr_en(bram_wr_en), .o_bram_wr_addr(bram_wr_addr), .o_bram_wr_data(bram_wr_data),
    .o_bram_rd_addr(bram_rd_addr), .i_bram_rd_data(bram_rd_data)
  );

  // Simple-dual-port RAM: 1-cycle read, old data on same-address write.
  logic [63:0] mem [DEPTH];
  always @(posedge clk) begin
    bram_rd_data <= mem[bram_rd_addr];
    if (bram_wr_en) mem[bram_wr_addr] <= bram_wr_data;
  end

  typedef struct {
    bit          hv;
    logic [8:0]  tid;
    logic [63:0] hd;
    bit          lv;
    logic [63:0] ld;
  } rsp_t;

  int          tests = 0;
  int          fails = 0;
  logic [63:0] shadow [DEPTH];
  int          sweep;
  rsp_t        q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_hit(input logic [15:0] a);
    return (a >= 16'h0030) && (a < 16'h0030 + 16'd1024) && (a % 2 == 0);
  endfunction

  task automatic idle();
    mmio_rd_valid = 0; mmio_wr_valid = 0; mmio_addr = '0; mmio_tid = '0; mmio_wr_data = '0;
    loc_req_valid = 0; loc_req_we = 0; loc_req_addr = '0; loc_req_wdata = '0;
  endtask

  task automatic clear_q();
    rsp_t e;
    e.hv = 0; e.tid = '0; e.hd = '0; e.lv = 0; e.ld = '0;
    q.delete();
    q.push_back(e);
    q.push_back(e);
  endtask

  // One clock cycle: inputs are already driven; outputs checked mid-cycle against the model.
  task automatic step();
    bit hr, hw, in_init, exp_rdy, lacc, wen, ren;
    int word, waddr, raddr;
    logic [63:0] wdata;
    rsp_t e, n;
    @(negedge clk);
    in_init = (sweep < DEPTH);
    word    = (int'(mmio_addr) - 'h30) / 2;
    hr      = mmio_rd_valid && is_hit(mmio_addr);
    hw      = mmio_wr_valid && is_hit(mmio_addr);
    exp_rdy = in_init ? 1'b0 : (loc_req_we ? !hw : !hr);
    lacc    = loc_req_valid && exp_rdy;
    chk("init_done", 64'(init_done), 64'(!in_init));
    chk("loc_req_ready", 64'(loc_req_ready), 64'(exp_rdy));

    wen = 1; waddr = 0; wdata = '0;
    if (in_init) waddr = sweep;
    else if (hw) begin waddr = word; wdata = mmio_wr_data; end
    else if (lacc && loc_req_we) begin waddr = int'(loc_req_addr); wdata = loc_req_wdata; end
    else wen = 0;
    chk("bram_wr_en", 64'(bram_wr_en), 64'(wen));
    if (wen) begin
      chk("bram_wr_addr", 64'(bram_wr_addr), 64'(waddr));
      chk("bram_wr_data", bram_wr_data, wdata);
    end

    ren = hr || (lacc && !loc_req_we);
    raddr = hr ? word : int'(loc_req_addr);
    if (ren) chk("bram_rd_addr", 64'(bram_rd_addr), 64'(raddr));

    e = q[q.size()-2];
    chk("mmio_rsp_valid", 64'(mmio_rsp_valid), 64'(e.hv));
    if (e.hv) begin
      chk("mmio_rsp_tid", 64'(mmio_rsp_tid), 64'(e.tid));
      chk("mmio_rsp_data", mmio_rsp_data, e.hd);
    end
    chk("loc_rsp_valid", 64'(loc_rsp_valid), 64'(e.lv));
    if (e.lv) chk("loc_rsp_data", loc_rsp_data, e.ld);

    n.hv = hr; n.tid = mmio_tid; n.lv = ren && !hr;
    n.hd = (FWD && wen && waddr == raddr) ? wdata : shadow[raddr];
    n.ld = n.hd;
    q.push_back(n);
    if (q.size() > 3) void'(q.pop_front());
    if (wen) shadow[waddr] = wdata;
    if (in_init) sweep++;
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int cycles);
    idle();
    rst = 1;
    @(posedge clk); #1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk("rst mmio_rsp_valid", 64'(mmio_rsp_valid), 64'd0);
      chk("rst mmio_rsp_tid", 64'(mmio_rsp_tid), 64'd0);
      chk("rst mmio_rsp_data", mmio_rsp_data, 64'd0);
      chk("rst loc_rsp_valid", 64'(loc_rsp_valid), 64'd0);
      chk("rst loc_rsp_data", loc_rsp_data, 64'd0);
      chk("rst init_done", 64'(init_done), 64'd0);
      chk("rst bram_wr_en", 64'(bram_wr_en), 64'd0);
      @(posedge clk); #1;
    end
    rst = 0;
    sweep = 0;
    clear_q();
  endtask

  initial begin
    int r;
    do_reset(3);

    // Sweep; a host read is serviced and a host write dropped during INIT.
    for (int i = 0; i < DEPTH; i++) begin
      idle();
      if (i == 10) begin
        mmio_rd_valid = 1; mmio_wr_valid = 1; mmio_addr = 16'h0034; mmio_tid = 9'h003;
        mmio_wr_data = 64'hFF;
      end
      step();
    end

    idle(); mmio_rd_valid = 1; mmio_addr = 16'h0030; mmio_tid = 9'h001; step();
    idle(); mmio_rd_valid = 1; mmio_addr = 16'h022E; mmio_tid = 9'h002; step();
    idle(); mmio_rd_valid = 1; mmio_addr = 16'h042E; mmio_tid = 9'h004; step();
    idle(); mmio_rd_valid = 1; mmio_addr = 16'h0034; mmio_tid = 9'h006; step();
    idle(); step(); step();
    chk("dropped init write", mmio_rsp_data, 64'd0);

    idle(); mmio_wr_valid = 1; mmio_addr = 16'h0040; mmio_wr_data = 64'hDEAD_BEEF_0123_4567; step();
    idle(); mmio_rd_valid = 1; mmio_addr = 16'h0040; mmio_tid = 9'h005; step();
    idle(); step();
    chk("rd 0x40 valid", 64'(mmio_rsp_valid), 64'd1);
    chk("rd 0x40 tid", 64'(mmio_rsp_tid), 64'h5);
    chk("rd 0x40 data", mmio_rsp_data, 64'hDEAD_BEEF_0123_4567);
    step();
    chk("rd 0x40 one cycle", 64'(mmio_rsp_valid), 64'd0);

    idle(); loc_req_valid = 1; loc_req_addr = 9'd8; step();
    idle(); step();
    chk("loc word8 valid", 64'(loc_rsp_valid), 64'd1);
    chk("loc word8 data", loc_rsp_data, 64'hDEAD_BEEF_0123_4567);
    step();

    // Local read blocked by a host read, accepted the following cycle.
    idle(); mmio_rd_valid = 1; mmio_addr = 16'h0040; mmio_tid = 9'h007;
    loc_req_valid = 1; loc_req_addr = 9'd3; step();
    mmio_rd_valid = 0; step();
    idle(); step(); step();

    // Same-cycle local write and host read of word 3.
    idle(); mmio_wr_valid = 1; mmio_addr = 16'h0036; mmio_wr_data = 64'h1; step();
    idle(); loc_req_valid = 1; loc_req_we = 1; loc_req_addr = 9'd3; loc_req_wdata = 64'h2;
    mmio_rd_valid = 1; mmio_addr = 16'h0036; mmio_tid = 9'h009; step();
    idle(); step();
    chk("rdw word3", mmio_rsp_data, FWD ? 64'h2 : 64'h1);
    step();

    // Non-hit host accesses.
    idle(); mmio_rd_valid = 1; mmio_addr = 16'h0020; step();
    idle(); mmio_rd_valid = 1; mmio_addr = 16'h0031; step();
    idle(); mmio_wr_valid = 1; mmio_addr = 16'h0430; mmio_wr_data = 64'h55; step();
    idle(); step(); step();

    for (int i = 0; i < 400; i++) begin
      idle();
      r = $urandom_range(0, 9);
      if (r < 7)       mmio_addr = 16'(16'h0030 + 2 * $urandom_range(0, 15));
      else if (r == 7) mmio_addr = 16'(16'h0031 + 2 * $urandom_range(0, 15));
      else if (r == 8) mmio_addr = 16'($urandom_range(0, 16'h2F));
      else             mmio_addr = 16'($urandom_range(16'h0430, 16'hFFFF));
      mmio_rd_valid = ($urandom_range(0, 2) == 0);
      mmio_wr_valid = ($urandom_range(0, 3) == 0);
      mmio_tid      = 9'($urandom);
      mmio_wr_data  = {$urandom, $urandom};
      loc_req_valid = ($urandom_range(0, 1) == 1);
      loc_req_we    = ($urandom_range(0, 2) == 0);
      loc_req_addr  = 9'($urandom_range(0, 15));
      loc_req_wdata = {$urandom, $urandom};
      step();
    end
    idle(); step(); step();

    // Reset mid-sweep with a host read in flight.
    do_reset(2);
    for (int i = 0; i < 200; i++) step();
    mmio_rd_valid = 1; mmio_addr = 16'h0040; mmio_tid = 9'h011; step();
    do_reset(3);
    for (int i = 0; i < DEPTH + 2; i++) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
